// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and default width.
package div_pkg;

    localparam int DEF_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {P,A} left, trial-subtract the divisor,
// keep the difference and set the new quotient bit when it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH:0]   p_nxt,
    output logic [WIDTH-1:0] a_nxt
);

    logic [WIDTH:0]        p_sh;
    logic signed [WIDTH:0] trial;
    logic                  trial_neg;

    always_comb begin
        p_sh  = {p[WIDTH-1:0], a[WIDTH-1]};
        trial = $signed(p_sh) - $signed({1'b0, dvs_mag});
        // A bit shifted out of P makes the true value exceed any divisor.
        trial_neg = trial[WIDTH] & ~p[WIDTH];
        if (trial_neg) begin
            p_nxt = p_sh;
            a_nxt = {a[WIDTH-2:0], 1'b0};
        end else begin
            p_nxt = $unsigned(trial);
            a_nxt = {a[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
// Quotient feeds ZLO and remainder feeds ZHI of the ALU Z register pair.
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] dvs_mag;
    logic             q_neg;
    logic             r_neg;
    logic             ovf_pend;

    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] a_step;

    logic             busy_d;
    logic             done_d;
    logic             dvs_zero;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && (v < 0)) ? negate(v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] fix_remainder(input logic [WIDTH-1:0] r,
                                                       input logic neg);
        return (neg && (r != '0)) ? negate(r) : r;
    endfunction

    assign dvs_zero = (divisor == '0);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .p      (p_q),
        .a      (a_q),
        .dvs_mag(dvs_mag),
        .p_nxt  (p_step),
        .a_nxt  (a_step)
    );

    // State register; busy/done are registered copies of the state decode.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = dvs_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state == CALC) || (state == FIX);
        done_d = (state == DONE);
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count     <= '0;
            p_q       <= '0;
            a_q       <= '0;
            dvs_mag   <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf_pend  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_zero <= dvs_zero;
                        ovf      <= 1'b0;
                        q_neg    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg    <= signed_op & dividend[WIDTH-1];
                        ovf_pend <= signed_op && (dividend == MIN_VAL) && (divisor == '1);
                        dvs_mag  <= magnitude(divisor, signed_op);
                        p_q      <= '0;
                        a_q      <= magnitude(dividend, signed_op);
                        count    <= CNT_W'(WIDTH - 1);
                        if (dvs_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                CALC: begin
                    p_q   <= p_step;
                    a_q   <= a_step;
                    count <= count - 1'b1;
                end
                FIX: begin
                    // MIN / -1 needs no special case: |MIN| with a positive sign is MIN again.
                    quotient  <= q_neg ? negate(a_q) : a_q;
                    remainder <= fix_remainder(p_q[WIDTH-1:0], r_neg);
                    ovf       <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_seq_div;

    logic clock = 1'b0;
    logic clear = 1'b0;

    logic        start32, sg32;
    logic [31:0] dvd32, dvs32;
    logic        busy32, done32, dz32, ov32;
    logic [31:0] q32, r32;

    logic        start8, sg8;
    logic [7:0]  dvd8, dvs8;
    logic        busy8, done8, dz8, ov8;
    logic [7:0]  q8, r8;

    logic        use8;
    logic        o_busy, o_done, o_dz, o_ov;
    logic [31:0] o_q, o_r;

    int checks = 0;
    int errors = 0;

    seq_div #(.WIDTH(32)) dut32 (
        .clock(clock), .clear(clear), .start(start32), .signed_op(sg32),
        .dividend(dvd32), .divisor(dvs32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_zero(dz32), .ovf(ov32)
    );

    seq_div #(.WIDTH(8)) dut8 (
        .clock(clock), .clear(clear), .start(start8), .signed_op(sg8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_zero(dz8), .ovf(ov8)
    );

    always #5 clock = ~clock;

    always_comb begin
        o_busy = use8 ? busy8 : busy32;
        o_done = use8 ? done8 : done32;
        o_dz   = use8 ? dz8 : dz32;
        o_ov   = use8 ? ov8 : ov32;
        o_q    = use8 ? {24'd0, q8} : q32;
        o_r    = use8 ? {24'd0, r8} : r32;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input int w, input bit sg, input logic [31:0] v);
        if (sg && v[w-1]) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    // Reference: plain integer division, truncating toward zero.
    function automatic void model(input int w, input bit sg, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output bit dz, output bit ov);
        logic [31:0] mask;
        longint sa, sb;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q  = mask;
            r  = a;
            dz = 1'b1;
        end else if (sg) begin
            sa = sx(w, 1'b1, a);
            sb = sx(w, 1'b1, b);
            if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                q  = a;
                r  = 32'd0;
                ov = 1'b1;
            end else begin
                q = 32'(sa / sb) & mask;
                r = 32'(sa % sb) & mask;
            end
        end else begin
            q = 32'(longint'(a) / longint'(b));
            r = 32'(longint'(a) % longint'(b));
        end
    endfunction

    task automatic do_div(input int w, input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input int inj);
        logic [31:0] eq, er;
        bit edz, eov;
        int cyc, done_cyc, busy_cnt;
        longint sq, sr, sa, sb;
        model(w, sg, a, b, eq, er, edz, eov);
        use8 = (w == 8);
        @(posedge clock); #1;
        if (w == 8) begin
            start8 = 1'b1; sg8 = sg; dvd8 = a[7:0]; dvs8 = b[7:0];
        end else begin
            start32 = 1'b1; sg32 = sg; dvd32 = a; dvs32 = b;
        end
        @(posedge clock); #1;
        start8 = 1'b0; start32 = 1'b0;
        cyc = 0;
        done_cyc = o_done ? 0 : -1;
        busy_cnt = o_busy ? 1 : 0;
        while (done_cyc < 0 && cyc < w + 8) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == inj) begin
                start8 = 1'b1; start32 = 1'b1;
                dvd8 = 8'h3C; dvs8 = 8'h05; dvd32 = 32'd999; dvs32 = 32'd3; sg32 = ~sg;
            end else begin
                start8 = 1'b0; start32 = 1'b0;
            end
            if (o_busy) busy_cnt++;
            if (o_done) done_cyc = cyc;
        end
        start8 = 1'b0; start32 = 1'b0;
        chk("latency", done_cyc, edz ? 1 : w + 2);
        chk("busy_cycles", busy_cnt, edz ? 0 : w + 1);
        chk("quotient", o_q, eq);
        chk("remainder", o_r, er);
        chk("div_zero", o_dz, edz);
        chk("ovf", o_ov, eov);
        if (!edz && !eov) begin
            sq = sx(w, sg, o_q); sr = sx(w, sg, o_r);
            sa = sx(w, sg, a);   sb = sx(w, sg, b);
            chk("identity", sq * sb + sr, sa);
            chk("rem_bound", ((sr < 0 ? -sr : sr) < (sb < 0 ? -sb : sb)) ? 1 : 0, 1);
        end
        @(posedge clock); #1;
        chk("done_pulse", o_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        bit rs, seen;
        start32 = 1'b0; sg32 = 1'b0; dvd32 = '0; dvs32 = '0;
        start8 = 1'b0; sg8 = 1'b0; dvd8 = '0; dvs8 = '0;
        use8 = 1'b0;

        #12;
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_quotient", q32, 0);
        chk("rst_remainder", r32, 0);
        chk("rst_div_zero", dz32, 0);
        chk("rst_ovf", ov32, 0);
        chk("rst_quotient8", q8, 0);
        #5 clear = 1'b1;

        do_div(32, 0, 32'd100, 32'd7, 0);
        chk("u100_7_q", o_q, 14);
        chk("u100_7_r", o_r, 2);
        do_div(32, 1, 32'hFFFF_FF9C, 32'd7, 0);
        chk("sm100_7_q", o_q, 32'hFFFF_FFF2);
        chk("sm100_7_r", o_r, 32'hFFFF_FFFE);
        do_div(32, 1, 32'd100, 32'hFFFF_FFF9, 0);
        chk("s100_m7_q", o_q, 32'hFFFF_FFF2);
        chk("s100_m7_r", o_r, 2);
        do_div(32, 0, 32'd5, 32'd0, 0);
        chk("dz_flag", o_dz, 1);
        chk("dz_q", o_q, 32'hFFFF_FFFF);
        chk("dz_r", o_r, 5);
        do_div(32, 0, 32'd100, 32'd7, 0);
        chk("dz_cleared", o_dz, 0);
        do_div(32, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("ovf_q", o_q, 32'h8000_0000);
        chk("ovf_r", o_r, 0);
        chk("ovf_flag", o_ov, 1);
        do_div(32, 0, 32'hFFFF_FFFF, 32'd2, 0);
        chk("umax_2_q", o_q, 32'h7FFF_FFFF);
        chk("umax_2_r", o_r, 1);
        chk("ovf_cleared", o_ov, 0);
        do_div(32, 0, 32'd100, 32'd7, 10);
        chk("ignored_start_q", o_q, 14);
        chk("ignored_start_r", o_r, 2);

        do_div(8, 1, 32'h80, 32'hFF, 0);
        do_div(8, 0, 32'hFF, 32'h01, 0);
        do_div(8, 1, 32'h80, 32'h00, 0);

        // Asynchronous reset in the middle of a division.
        use8 = 1'b0;
        @(posedge clock); #1;
        start32 = 1'b1; sg32 = 1'b0; dvd32 = 32'd1234567; dvs32 = 32'd89;
        @(posedge clock); #1;
        start32 = 1'b0;
        repeat (19) @(posedge clock);
        #1 clear = 1'b0;
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_q", o_q, 0);
        chk("abort_r", o_r, 0);
        chk("abort_dz", o_dz, 0);
        chk("abort_ovf", o_ov, 0);
        #3 clear = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (o_done || o_busy) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 32'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0:       rb = 32'h00;
                1:       rb = 32'hFF;
                2:       begin rb = 32'hFF; ra = 32'h80; end
                default: rb = 32'($urandom_range(1, 255));
            endcase
            do_div(8, rs, ra, rb, 0);
        end

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            do_div(32, rs, ra, rb, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle, parametrised integer divider for the ALU's DIV path. It produces one quotient bit per clock, so there is no long combinational shift-subtract chain. It supports signed and unsigned operands, a start/done handshake, and flags divide-by-zero and signed overflow. Results go into the ALU's Z register pair: quotient to ZLO, remainder to ZHI.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- dividend  in  WIDTH  numerator; captured with start
- divisor  in  WIDTH  denominator; captured with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; results valid from this cycle on
- quotient  out  WIDTH  result, held until the next accepted start
- remainder  out  WIDTH  result, held until the next accepted start
- div_zero  out  1  divisor was 0; held with the results
- ovf  out  1  signed MIN / −1; held with the results

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Latch the operands and signed_op.
  - If signed, convert both operands to magnitudes and record the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
  - If divisor == 0, go to DONE with quotient = all-ones, remainder = dividend, div_zero = 1.
  - Otherwise clear the partial remainder P (WIDTH+1 bits), load A = |dividend|, set count = WIDTH−1, and go to CALC.
- CALC, once per cycle (restoring step):
  - Shift {P,A} left by 1 and form T = P − |divisor| at WIDTH+1 bits.
  - If T is negative, A[0] = 0 and P keeps its shifted value.
  - Otherwise P = T and A[0] = 1.
  - Decrement count. After the step with count == 0, go to FIX.
- FIX:
  - Negate the quotient if the quotient sign is 1. Negate the remainder if the remainder sign is 1 and it is nonzero.
  - Signed results truncate toward zero; the remainder takes the dividend's sign.
  - Signed MIN / −1 gives quotient = MIN, remainder = 0, ovf = 1.
  - Go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE. Results and flags are unchanged until the next accepted start.
- start outside IDLE is ignored; it is not queued.
- start in the cycle DONE returns to IDLE is not accepted. The requester must wait for the IDLE cycle.
- Accepting a new start clears div_zero and ovf. quotient and remainder are only updated at FIX or at the divide-by-zero entry to DONE.

## Timing
- Reset (clear=0, asynchronous): state = IDLE; busy, done, div_zero and ovf = 0; quotient and remainder = 0; internal registers cleared.
- Reset mid-operation aborts the division immediately. No done is produced.
- start accepted at edge 0:
  - CALC occupies edges 1..WIDTH.
  - FIX is at edge WIDTH+1.
  - done is high during the cycle after edge WIDTH+2 (latency WIDTH+2; 34 for WIDTH=32).
- Divide-by-zero: done is high after edge 1 (latency 1).
- busy = (state ≠ IDLE) && (state ≠ DONE).
- Throughput: one division every WIDTH+3 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package div_pkg holds the state encoding localparams (IDLE, CALC, FIX, DONE) and the default WIDTH.
- Sub-module div_step, combinational, parametrised by WIDTH:
  - Inputs: P, A, |divisor|.
  - Outputs: next P, next A.
  - Performs one shift-compare-subtract iteration and is instantiated once in the CALC datapath.
- Top level: FSM, counter of $clog2(WIDTH) bits, operand capture, magnitude/negate logic, output registers.

## Test plan
- Unsigned 100 / 7, WIDTH=32 → quotient 14, remainder 2, done exactly 34 cycles after start, busy high for cycles 1..33.
- Signed −100 / 7 → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 100 / −7 → quotient 0xFFFFFFF2, remainder 2.
- Unsigned 5 / 0 → div_zero=1, quotient 0xFFFFFFFF, remainder 5, done 1 cycle after start; next valid start clears div_zero.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, ovf=1. Unsigned 0xFFFFFFFF / 2 → quotient 0x7FFFFFFF, remainder 1, ovf=0.
- start pulsed at cycle 10 of a busy division → ignored, and the first result is unchanged. Then clear=0 asserted at cycle 20 of a new division → busy, done and outputs are 0 immediately, and no done follows.
- Random regression at WIDTH=8 and WIDTH=32, signed and unsigned, against a reference model: quotient×divisor + remainder == dividend and |remainder| < |divisor|.
